// File: rtl/sonata_pkg.sv
// Shared types and constants for the SPI bus arbiter and its round-robin picker.
// The arbiter states, the requester limit and the hold-counter width live here.
package sonata_pkg;

  localparam int SpiArbMaxReq   = 8;
  localparam int SpiArbHoldCntW = 16;
  localparam int SpiArbIdxW     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    GUARD = 2'd2
  } arb_state_e;

  // (base + off) mod n, for base < n and off <= n
  function automatic logic [SpiArbIdxW-1:0] rr_wrap(input logic [SpiArbIdxW-1:0] base,
                                                    input int off, input int n);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= n) ? sum - n : sum;
    return sum[SpiArbIdxW-1:0];
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request found searching
// upward from ptr_i + 1 (wrapping) wins.
module rr_pick
  import sonata_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req_i,
  input  logic [SpiArbIdxW-1:0] ptr_i,
  output logic [N-1:0]          gnt_o,
  output logic [SpiArbIdxW-1:0] idx_o,
  output logic                  valid_o
);

  logic [SpiArbMaxReq-1:0] req_pad;
  logic [SpiArbIdxW-1:0]   cand;
  logic                    hit;

  assign req_pad = SpiArbMaxReq'(req_i);

  // Priority search over the rotated request vector, then one-hot encode the winner.
  always_comb begin
    idx_o   = {SpiArbIdxW{1'b0}};
    valid_o = 1'b0;
    cand    = {SpiArbIdxW{1'b0}};
    hit     = 1'b0;
    gnt_o   = {N{1'b0}};
    for (int off = 1; off <= N; off++) begin
      cand    = rr_wrap(ptr_i, off, N);
      hit     = !valid_o && req_pad[cand];
      idx_o   = hit ? cand : idx_o;
      valid_o = valid_o | hit;
    end
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = valid_o && (idx_o == SpiArbIdxW'(i));
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between NumReq hosts: whole-transaction round-robin grants,
// a chip-select guard gap between owners and optional eviction of long holders.
module spi_bus_arbiter
  import sonata_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int GuardCycles   = 2,
  parameter int MaxHoldCycles = 0
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  input  logic [NumReq-1:0] req_sck_i,
  input  logic [NumReq-1:0] req_copi_i,
  input  logic [NumReq-1:0] req_cs_ni,
  output logic [NumReq-1:0] req_cipo_o,
  output logic              spi_sck_o,
  output logic              spi_copi_o,
  output logic              spi_cs_no,
  input  logic              spi_cipo_i,
  output logic              timeout_o,
  output logic [2:0]        timeout_id_o,
  output logic              busy_o
);

  localparam int HoldW = SpiArbHoldCntW;
  localparam logic              GuardEn   = (GuardCycles > 0);
  localparam logic              HoldEn    = (MaxHoldCycles > 0);
  localparam logic [7:0]        GuardLast = (GuardCycles > 0) ? 8'(GuardCycles - 1) : 8'd0;
  localparam logic [HoldW-1:0]  HoldLast  = (MaxHoldCycles > 0) ? HoldW'(MaxHoldCycles - 1)
                                                                : {HoldW{1'b0}};
  localparam logic [HoldW-1:0]  HoldMax   = {HoldW{1'b1}};
  localparam logic [HoldW-1:0]  HoldOne   = HoldW'(1'b1);
  localparam logic [SpiArbIdxW-1:0] PtrInit = SpiArbIdxW'(NumReq - 1);

  arb_state_e              state_q, state_d;
  logic [NumReq-1:0]       gnt_q, gnt_d;
  logic [SpiArbIdxW-1:0]   owner_q, owner_d;
  logic [SpiArbIdxW-1:0]   rr_q, rr_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NumReq-1:0]       blocked_q, blocked_d;
  logic                    timeout_q, timeout_d;
  logic [SpiArbIdxW-1:0]   timeout_id_q, timeout_id_d;
  logic                    busy_q, busy_d;

  logic [NumReq-1:0]       eligible;
  logic [NumReq-1:0]       pick_gnt;
  logic [SpiArbIdxW-1:0]   pick_idx;
  logic                    pick_valid;
  logic [SpiArbMaxReq-1:0] req_pad;
  logic [SpiArbMaxReq-1:0] sck_pad;
  logic [SpiArbMaxReq-1:0] copi_pad;
  logic [SpiArbMaxReq-1:0] cs_pad;
  logic                    owner_req;
  logic                    evict;

  assign eligible = req_i & ~blocked_q;
  assign req_pad  = SpiArbMaxReq'(req_i);
  assign sck_pad  = SpiArbMaxReq'(req_sck_i);
  assign copi_pad = SpiArbMaxReq'(req_copi_i);
  assign cs_pad   = SpiArbMaxReq'(req_cs_ni);

  rr_pick #(
    .N (NumReq)
  ) u_rr_pick (
    .req_i   (eligible),
    .ptr_i   (rr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state logic: grant, release/eviction, guard countdown and blocked bits.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = {SpiArbIdxW{1'b0}};
    evict        = 1'b0;
    owner_req    = req_pad[owner_q];
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          rr_d    = pick_idx;
          hold_d  = {HoldW{1'b0}};
        end else begin
          gnt_d = {NumReq{1'b0}};
        end
      end
      OWN: begin
        // A voluntary release in the limit cycle takes precedence over eviction.
        if (!owner_req || (HoldEn && (hold_q == HoldLast))) begin
          gnt_d = {NumReq{1'b0}};
          if (GuardEn) begin
            state_d = GUARD;
            cnt_d   = GuardLast;
          end else begin
            state_d = IDLE;
          end
          if (owner_req) begin
            evict        = 1'b1;
            timeout_d    = 1'b1;
            timeout_id_d = owner_q;
          end else begin
            evict = 1'b0;
          end
        end else begin
          hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HoldOne;
        end
      end
      GUARD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {NumReq{1'b0}};
      end
    endcase
    for (int i = 0; i < NumReq; i++) begin
      blocked_d[i] = (blocked_q[i] & req_i[i]) | (evict & (owner_q == SpiArbIdxW'(i)));
    end
    busy_d = (state_d != IDLE);
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q      <= IDLE;
      gnt_q        <= {NumReq{1'b0}};
      owner_q      <= {SpiArbIdxW{1'b0}};
      rr_q         <= PtrInit;
      hold_q       <= {HoldW{1'b0}};
      cnt_q        <= 8'd0;
      blocked_q    <= {NumReq{1'b0}};
      timeout_q    <= 1'b0;
      timeout_id_q <= {SpiArbIdxW{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      blocked_q    <= blocked_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;
  assign busy_o       = busy_q;

  // Bus mux: only the owner reaches the pads; the bus idles with cs_n high otherwise.
  always_comb begin
    spi_sck_o  = 1'b0;
    spi_copi_o = 1'b0;
    spi_cs_no  = 1'b1;
    req_cipo_o = {NumReq{1'b0}};
    if (state_q == OWN) begin
      spi_sck_o  = sck_pad[owner_q];
      spi_copi_o = copi_pad[owner_q];
      spi_cs_no  = cs_pad[owner_q];
      for (int i = 0; i < NumReq; i++) begin
        req_cipo_o[i] = (owner_q == SpiArbIdxW'(i)) & spi_cipo_i;
      end
    end else begin
      spi_cs_no = 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed scenarios followed by random
// request traffic, all compared against a cycle-level reference model.
module tb_spi_bus_arbiter;

  localparam int N = 3;
  localparam int G = 2;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0, sck = '0, copi = '0, csn = '1;
  logic         cipo = 1'b0;
  logic [N-1:0] gnt, req_cipo;
  logic         sck_o, copi_o, cs_o, tmo, busy;
  logic [2:0]   tmo_id;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.NumReq(N), .GuardCycles(G), .MaxHoldCycles(M)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .req_i(req), .gnt_o(gnt),
    .req_sck_i(sck), .req_copi_i(copi), .req_cs_ni(csn), .req_cipo_o(req_cipo),
    .spi_sck_o(sck_o), .spi_copi_o(copi_o), .spi_cs_no(cs_o), .spi_cipo_i(cipo),
    .timeout_o(tmo), .timeout_id_o(tmo_id), .busy_o(busy)
  );

  int n_vec = 0, n_miss = 0;

  // Reference model: edge count, current owner, earliest edge a new grant may happen.
  int e = 0, m_owner = -1, m_gedge = 0, m_next = 0, m_last = N - 1, m_toid = 0;
  bit m_to = 1'b0;
  bit m_blk[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_next = 0; m_last = N - 1; m_to = 1'b0; m_toid = 0;
    for (int i = 0; i < N; i++) m_blk[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit nb[N];
    int c;
    e++;
    m_to = 1'b0; m_toid = 0;
    for (int i = 0; i < N; i++) nb[i] = m_blk[i] && req[i];
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_next = e + G + 1;
      end else if (M > 0 && (e - m_gedge) == M) begin
        m_to = 1'b1; m_toid = m_owner; nb[m_owner] = 1'b1;
        m_owner = -1; m_next = e + G + 1;
      end
    end else if (e >= m_next) begin
      for (int off = 1; off <= N; off++) begin
        c = (m_last + off) % N;
        if (m_owner < 0 && req[c] && !m_blk[c]) begin
          m_owner = c; m_gedge = e; m_last = c;
        end
      end
    end
    for (int i = 0; i < N; i++) m_blk[i] = nb[i];
  endtask

  task automatic check_mux();
    logic [N-1:0] ec;
    ec = '0;
    if (m_owner >= 0) begin
      ec[m_owner] = cipo;
      chk("bus_sck", 32'(sck_o), 32'(sck[m_owner]));
      chk("bus_copi", 32'(copi_o), 32'(copi[m_owner]));
      chk("bus_cs", 32'(cs_o), 32'(csn[m_owner]));
    end else begin
      chk("idle_sck", 32'(sck_o), 32'(1'b0));
      chk("idle_copi", 32'(copi_o), 32'(1'b0));
      chk("idle_cs", 32'(cs_o), 32'(1'b1));
    end
    chk("cipo_route", 32'(req_cipo), 32'(ec));
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(oh(m_owner)));
    chk("timeout", 32'(tmo), 32'(m_to));
    if (m_to) chk("timeout_id", 32'(tmo_id), 32'(m_toid));
    chk("busy", 32'(busy), 32'(m_owner >= 0 || e < m_next - 1));
    check_mux();
  endtask

  task automatic step();
    #1;
    check_mux();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int prev, ngr;
    int tmr[N];
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'(3'b000));
    chk("rst_cs", 32'(cs_o), 32'(1'b1));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_timeout", 32'(tmo), 32'(1'b0));
    chk("rst_cipo", 32'(req_cipo), 32'(3'b000));
    rst = 1'b0;
    model_reset();

    // First grant, release and guard gap
    csn = '0;
    req = 3'b011;
    step();
    chk("first_gnt", 32'(gnt), 32'(3'b001));
    repeat (3) step();
    req[0] = 1'b0;
    step();
    chk("rel_gnt", 32'(gnt), 32'(3'b000));
    chk("rel_cs", 32'(cs_o), 32'(1'b1));
    step();
    chk("guard1_gnt", 32'(gnt), 32'(3'b000));
    step();
    chk("guard2_gnt", 32'(gnt), 32'(3'b000));
    step();
    chk("guard_gnt", 32'(gnt), 32'(3'b010));

    // Mux while requester 1 owns
    sck[1] = 1'b1; copi[1] = 1'b1; cipo = 1'b1;
    #1;
    chk("mux_sck", 32'(sck_o), 32'(1'b1));
    chk("mux_copi", 32'(copi_o), 32'(1'b1));
    chk("mux_cipo", 32'(req_cipo), 32'(3'b010));
    sck[1] = 1'b0; sck[0] = 1'b1;
    #1;
    chk("mux_other_sck", 32'(sck_o), 32'(1'b0));
    step();
    req[1] = 1'b0;
    step();
    repeat (3) step();

    // Fairness: everyone requests, 4-ish cycle transactions
    prev = -1; ngr = 0;
    repeat (60) begin
      for (int i = 0; i < N; i++) req[i] = !(m_owner == i && (e - m_gedge) >= 4);
      step();
      if (m_owner >= 0 && m_gedge == e) begin
        if (prev >= 0) chk("rr_order", 32'(gnt), 32'(oh((prev + 1) % N)));
        prev = m_owner;
        ngr++;
      end
    end
    chk("rr_grants", 32'(ngr >= 6), 32'(1'b1));
    req = '0;
    repeat (4) step();

    // Asynchronous reset mid-transaction
    req = 3'b001;
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'(3'b000));
    chk("arst_cs", 32'(cs_o), 32'(1'b1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();

    // Eviction of a long holder
    req = 3'b011;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'(3'b001));
    repeat (7) step();
    chk("pre_to", 32'(tmo), 32'(1'b0));
    step();
    chk("to_pulse", 32'(tmo), 32'(1'b1));
    chk("to_id", 32'(tmo_id), 32'(3'd0));
    chk("to_gnt", 32'(gnt), 32'(3'b000));
    step();
    chk("to_once", 32'(tmo), 32'(1'b0));
    repeat (2) step();
    chk("after_to_gnt", 32'(gnt), 32'(3'b010));
    repeat (2) step();
    req[1] = 1'b0;
    step();
    repeat (4) step();
    chk("blocked_wait", 32'(gnt), 32'(3'b000));
    req[0] = 1'b0;
    step();
    req[0] = 1'b1;
    step();
    chk("regrant", 32'(gnt), 32'(3'b001));

    // Release in exactly the timeout cycle
    repeat (7) step();
    req[0] = 1'b0;
    step();
    chk("rel_at_limit_to", 32'(tmo), 32'(1'b0));
    chk("rel_at_limit_gnt", 32'(gnt), 32'(3'b000));
    repeat (4) step();

    // Random traffic
    for (int i = 0; i < N; i++) tmr[i] = $urandom_range(1, 12);
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if (tmr[i] == 0) begin
          req[i] = ~req[i];
          tmr[i] = $urandom_range(1, 12);
        end else begin
          tmr[i]--;
        end
      end
      sck  = N'($urandom);
      copi = N'($urandom);
      csn  = N'($urandom);
      cipo = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
